// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared types and constants for the nibble-serial adder
// Package serial_add_pkg: controller state enum and nibble width.
// Optional subtract support is selected by the macro SERIAL_ADD_SUB_EN (used in the
// interface and top, not here).
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/response bundle for serial_add_ctrl
// Interface serial_add_ctrl_if #(WIDTH):
//   request  : req_valid, req_ready, op_a, op_b, cin (+ sub when SERIAL_ADD_SUB_EN)
//   response : rsp_valid, rsp_ready, sum, cout, ovf
// Modports: master (requester/consumer side), slave (the adder controller).
interface serial_add_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output req_valid, op_a, op_b, cin, rsp_ready,
    input  req_ready, rsp_valid, sum, cout, ovf
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  req_valid, op_a, op_b, cin, rsp_ready,
    output req_ready, rsp_valid, sum, cout, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_adder.sv
// rtl/serial_add_ctrl_adder.sv - 4-bit ripple full adder used one nibble per cycle
// Module full_adder_4bit:
//   carry_in  : carry into bit 0
//   data_a/b  : 4-bit addends
//   sum       : 4-bit result
//   carry_out : carry out of bit 3
module full_adder_4bit (
  input  logic       carry_in,
  input  logic [3:0] data_a,
  input  logic [3:0] data_b,
  output logic [3:0] sum,
  output logic       carry_out
);

  assign {carry_out, sum} = {1'b0, data_a} + {1'b0, data_b} + {4'b0000, carry_in};

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial adder with valid/ready request and response
// Computes op_a + op_b + cin over WIDTH/4 cycles using a single full_adder_4bit,
// least significant nibble first.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_add_ctrl_if.slave (request, response, sum/cout/ovf)
// Parameter WIDTH: multiple of 4, at least 8.
// Macro SERIAL_ADD_SUB_EN: adds bus.sub; sub=1 computes op_a + ~op_b + 1, cin ignored.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int CNT_W = $clog2(N);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic [NIBBLE_W-1:0] fa_sum;
  logic                fa_cout;
  logic                msb_cin;
  logic                last_nibble;

  // Operands shift right one nibble per RUN edge, so the adder always sees bits [3:0].
  full_adder_4bit u_fa (
    .carry_in  (carry),
    .data_a    (a_q[NIBBLE_W-1:0]),
    .data_b    (b_q[NIBBLE_W-1:0]),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // Carry into the MSB recovered from the top nibble's bit 3: s = a ^ b ^ c.
  assign msb_cin     = a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1] ^ fa_sum[NIBBLE_W-1];
  assign last_nibble = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_q   <= bus.op_a;
            cnt   <= '0;
            state <= RUN;
`ifdef SERIAL_ADD_SUB_EN
            // Subtraction as two's complement: invert op_b and force the carry-in.
            b_q   <= bus.sub ? ~bus.op_b : bus.op_b;
            carry <= bus.sub ? 1'b1 : bus.cin;
`else
            b_q   <= bus.op_b;
            carry <= bus.cin;
`endif
          end
        end
        RUN: begin
          // New nibble enters at the top; after N edges sum_q holds the full result.
          sum_q <= {fa_sum, sum_q[WIDTH-1:NIBBLE_W]};
          a_q   <= a_q >> NIBBLE_W;
          b_q   <= b_q >> NIBBLE_W;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last_nibble) begin
            cout_q <= fa_cout;
            ovf_q  <= msb_cin ^ fa_cout;
            carry  <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=32)
// Honours SERIAL_ADD_SUB_EN when defined.
module tb_serial_add_ctrl;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c, input logic s);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             cc;
    logic             ov;
    bb   = s ? ~b : b;
    cc   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    ov   = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ov, full};
  endfunction

  // Model: one job at a time; result due N edges after accept; retired by handshake.
  logic             have_job = 1'b0;
  logic             prev_acc = 1'b0;
  logic             prev_hs  = 1'b0;
  int               acc_cyc  = 0;
  logic [WIDTH-1:0] pa, pb, e_sum;
  logic             pc, ps, e_cout, e_ovf, exp_rv;

  always @(negedge clk) begin
    if (rst) begin
      have_job = 1'b0;
      prev_acc = 1'b0;
      prev_hs  = 1'b0;
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_sum", 64'(bus.sum), 64'(0));
      chk("rst_cout", 64'(bus.cout), 64'(0));
      chk("rst_ovf", 64'(bus.ovf), 64'(0));
    end else begin
      if (prev_hs) have_job = 1'b0;
      if (prev_acc) begin
        have_job = 1'b1;
        acc_cyc  = cyc;
        {e_ovf, e_cout, e_sum} = ref_add(pa, pb, pc, ps);
      end
      exp_rv = have_job && ((cyc - acc_cyc) >= N);
      chk("model_req_ready", 64'(bus.req_ready), 64'(!have_job));
      chk("model_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("model_sum", 64'(bus.sum), 64'(e_sum));
        chk("model_cout", 64'(bus.cout), 64'(e_cout));
        chk("model_ovf", 64'(bus.ovf), 64'(e_ovf));
      end
      prev_acc = bus.req_valid && !have_job;
      prev_hs  = exp_rv && bus.rsp_ready;
      pa = bus.op_a;
      pb = bus.op_b;
      pc = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
      ps = bus.sub;
`else
      ps = 1'b0;
`endif
    end
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;
  int               r_lat;

  // Issues one request from posedge+1 and returns with the result on the bus.
  // If rsp_ready is high the handshake edge is also consumed.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic s);
    bit got;
    bus.op_a = a;
    bus.op_b = b;
    bus.cin  = c;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub  = s;
`else
    if (s) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    bus.req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.req_ready;
    end
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    r_lat = 0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk);
      #1;
      r_lat++;
      got = bus.rsp_valid;
    end
    if (!got) chk("rsp_timeout", 64'(0), 64'(1));
    r_sum  = bus.sum;
    r_cout = bus.cout;
    r_ovf  = bus.ovf;
    if (bus.rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  int acc_t[4];
  logic [WIDTH-1:0] va[4];
  logic [WIDTH-1:0] vb[4];

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit got;
    bus.req_valid = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cin       = 1'b0;
    bus.rsp_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(bus.req_ready), 64'(1));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_sum", 64'(bus.sum), 64'(0));
    rst = 1'b0;

    run_op(32'h00000001, 32'h00000003, 1'b1, 1'b0);
    chk("t1_latency", 64'(r_lat), 64'(8));
    chk("t1_sum", 64'(r_sum), 64'h00000005);
    chk("t1_cout", 64'(r_cout), 64'(0));
    chk("t1_ovf", 64'(r_ovf), 64'(0));

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk("t2_sum", 64'(r_sum), 64'h00000000);
    chk("t2_cout", 64'(r_cout), 64'(1));
    chk("t2_ovf", 64'(r_ovf), 64'(0));

    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk("t3_sum", 64'(r_sum), 64'h80000000);
    chk("t3_cout", 64'(r_cout), 64'(0));
    chk("t3_ovf", 64'(r_ovf), 64'(1));

    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    chk("t4_sum", 64'(r_sum), 64'hACF13568);
    chk("t4_cout", 64'(r_cout), 64'(0));

    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Hold result in DONE while a new request with new operands is presented.
    bus.rsp_ready = 1'b0;
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
    chk("hold_sum0", 64'(r_sum), 64'h00000001);
    chk("hold_cout0", 64'(r_cout), 64'(1));
    chk("hold_ovf0", 64'(r_ovf), 64'(1));
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.op_a      = $urandom;
      bus.op_b      = $urandom;
      bus.cin       = ~bus.cin;
      @(posedge clk);
      #1;
      chk("hold_sum", 64'(bus.sum), 64'h00000001);
      chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_ready", 64'(bus.req_ready), 64'(1));
    chk("hold_release_valid", 64'(bus.rsp_valid), 64'(0));

    // Reset four edges into RUN.
    bus.op_a      = 32'h11111111;
    bus.op_b      = 32'h22222222;
    bus.cin       = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", 64'(bus.sum), 64'(0));
    chk("mid_rst_cout", 64'(bus.cout), 64'(0));
    chk("mid_rst_ovf", 64'(bus.ovf), 64'(0));
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    chk("post_rst_sum", 64'(r_sum), 64'h00010000);
    chk("post_rst_latency", 64'(r_lat), 64'(8));

`ifdef SERIAL_ADD_SUB_EN
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    chk("sub_sum", 64'(r_sum), 64'hFFFFFFFE);
    chk("sub_cout", 64'(r_cout), 64'(0));
    chk("sub_ovf", 64'(r_ovf), 64'(0));
    bus.sub = 1'b0;
`endif

    // Back-to-back with req_valid and rsp_ready held high.
    va[0] = 32'h00000010; vb[0] = 32'h00000020;
    va[1] = 32'hFFFF0000; vb[1] = 32'h00010000;
    va[2] = 32'h7FFFFFF0; vb[2] = 32'h00000010;
    va[3] = 32'hDEADBEEF; vb[3] = 32'h01010101;
    bus.rsp_ready = 1'b1;
    bus.cin       = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.op_a = va[i];
      bus.op_b = vb[i];
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        got = bus.req_ready;
      end
      if (!got) chk("b2b_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      acc_t[i] = cyc;
    end
    bus.req_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b_period", 64'(acc_t[i] - acc_t[i-1]), 64'(10));
    repeat (N + 4) @(posedge clk);
    #1;
    chk("final_idle", 64'(bus.req_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
